// File: rtl/sram_bist.sv
// sram_bist: March C- built-in self-test controller for the generic `sram`.
// Drives the memory port one operation per cycle and checks every read
// against the expected data background after READ_LATENCY edges.
// Optional build macro: SRAM_BIST_STOP_ON_FAIL_EN (stop issuing on the first
// mismatch and go straight to DRAIN/DONE).
module sram_bist #(
  parameter int SIZE         = 16,
  parameter int DATA_WIDTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [$clog2(SIZE)-1:0]  fail_addr,
  output logic [2:0]               fail_element,
  output logic                     mem_en,
  output logic                     mem_rw,
  output logic [$clog2(SIZE)-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_in,
  input  logic [DATA_WIDTH-1:0]    mem_out
);

  localparam int AW = $clog2(SIZE);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(SIZE - 1);
  localparam logic [1:0]    DRAIN_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_d;

  logic [2:0]            elem, elem_d;
  logic [1:0]            drain_cnt, drain_d;
  logic                  busy_d, done_d, fail_d;
  logic [AW-1:0]         fail_addr_d;
  logic [2:0]            fail_element_d;
  logic                  mem_en_d, mem_rw_d;
  logic [AW-1:0]         mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_in_d;

  logic [2:0]            nxt_elem;
  logic [AW-1:0]         nxt_addr;
  logic                  nxt_rw;
  logic                  last_op;
  logic                  at_end;
  logic                  mismatch;
  logic                  stop_now;

  // Read-tracking pipeline, one stage per edge of read latency
  logic                  pv    [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pexp  [READ_LATENCY];
  logic [AW-1:0]         paddr [READ_LATENCY];
  logic [2:0]            pelem [READ_LATENCY];

  // Background left in memory after element e: M1/M3 write ones, others zeros
  function automatic logic [DATA_WIDTH-1:0] bg_after(input logic [2:0] e);
    if (e == 3'd1 || e == 3'd3) return '1;
    return '0;
  endfunction

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  assign mismatch = pv[READ_LATENCY-1] && (mem_out != pexp[READ_LATENCY-1]);

`ifdef SRAM_BIST_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // Next March operation following the one currently on the memory bus
  always_comb begin
    nxt_elem = elem;
    nxt_addr = mem_addr;
    nxt_rw   = 1'b1;
    last_op  = (elem == 3'd5) && (mem_addr == LAST_ADDR);
    at_end   = is_down(elem) ? (mem_addr == '0) : (mem_addr == LAST_ADDR);
    if (!mem_rw && elem != 3'd5) begin
      nxt_rw = 1'b1;
    end else begin
      if (at_end) begin
        nxt_elem = elem + 3'd1;
        nxt_addr = is_down(nxt_elem) ? LAST_ADDR : '0;
      end else begin
        nxt_addr = is_down(elem) ? (mem_addr - AW'(1)) : (mem_addr + AW'(1));
      end
      nxt_rw = (nxt_elem == 3'd0);
    end
  end

  // FSM next-state and next registered outputs
  always_comb begin
    state_d        = state;
    elem_d         = elem;
    drain_d        = drain_cnt;
    busy_d         = busy;
    done_d         = done;
    fail_d         = fail;
    fail_addr_d    = fail_addr;
    fail_element_d = fail_element;
    mem_en_d       = 1'b0;
    mem_rw_d       = 1'b0;
    mem_addr_d     = mem_addr;
    mem_in_d       = mem_in;

    if (mismatch && !fail) begin
      fail_d         = 1'b1;
      fail_addr_d    = paddr[READ_LATENCY-1];
      fail_element_d = pelem[READ_LATENCY-1];
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d        = RUN;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          fail_d         = 1'b0;
          fail_addr_d    = '0;
          fail_element_d = '0;
          elem_d         = 3'd0;
          mem_en_d       = 1'b1;
          mem_rw_d       = 1'b1;
          mem_addr_d     = '0;
          mem_in_d       = '0;
        end
      end
      RUN: begin
        if (last_op || stop_now) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          mem_en_d   = 1'b1;
          mem_rw_d   = nxt_rw;
          mem_addr_d = nxt_addr;
          elem_d     = nxt_elem;
          if (nxt_rw) mem_in_d = bg_after(nxt_elem);
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_cnt + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered output update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      elem         <= '0;
      drain_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      fail_addr    <= '0;
      fail_element <= '0;
      mem_en       <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_in       <= '0;
    end else begin
      state        <= state_d;
      elem         <= elem_d;
      drain_cnt    <= drain_d;
      busy         <= busy_d;
      done         <= done_d;
      fail         <= fail_d;
      fail_addr    <= fail_addr_d;
      fail_element <= fail_element_d;
      mem_en       <= mem_en_d;
      mem_rw       <= mem_rw_d;
      mem_addr     <= mem_addr_d;
      mem_in       <= mem_in_d;
    end
  end

  // Track each issued read until its data appears on mem_out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pv[i]    <= 1'b0;
        pexp[i]  <= '0;
        paddr[i] <= '0;
        pelem[i] <= '0;
      end
    end else begin
      pv[0]    <= mem_en && !mem_rw;
      pexp[0]  <= bg_after(elem - 3'd1);
      paddr[0] <= mem_addr;
      pelem[0] <= elem;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pv[i]    <= pv[i-1];
        pexp[i]  <= pexp[i-1];
        paddr[i] <= paddr[i-1];
        pelem[i] <= pelem[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sram_bist.sv
// Testbench for sram_bist with a behavioural single-cycle sram and an
// injectable stuck-at read fault. Expected operation streams and failure
// results come from a March C- model built from the algorithm's rules.
module tb_sram_bist;

  localparam int N   = 16;
  localparam int DW  = 4;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic          busy, done, fail;
  logic [3:0]    fail_addr;
  logic [2:0]    fail_element;
  logic          mem_en, mem_rw;
  logic [3:0]    mem_addr;
  logic [DW-1:0] mem_in, mem_out;

  always #5 clk = ~clk;

  sram_bist #(.SIZE(N), .DATA_WIDTH(DW), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_element(fail_element),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_out(mem_out)
  );

  // Behavioural sram with an optional stuck bit on reads of one address
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rd_val;
  logic          flt_on = 1'b0;
  int            flt_addr = 0, flt_bit = 0;
  logic          flt_val = 1'b0;

  always_comb begin
    rd_val = mem[mem_addr];
    if (flt_on && int'(mem_addr) == flt_addr) rd_val[flt_bit] = flt_val;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rw) mem[mem_addr] <= mem_in;
      else        mem_out <= rd_val;
    end
  end

  typedef struct {
    logic          rw;
    int            addr;
    logic [DW-1:0] data;
  } op_t;

  op_t ref_q[$];
  op_t obs_q[$];
  int  exp_ops, exp_fail, exp_faddr, exp_felem;
  int  busy_cnt;
  bit  timed_out;
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic logic [DW-1:0] bg(input int e);
    return (e == 1 || e == 3) ? 4'hF : 4'h0;
  endfunction

  // March C- expected stream and first failure for a given stuck-at fault
  task automatic build_ref(input bit f_on, input int fa, input int fb, input logic sv);
    int kfail;
    logic [DW-1:0] seen;
    op_t o;
    ref_q.delete();
    kfail = -1; exp_fail = 0; exp_faddr = 0; exp_felem = 0;
    for (int e = 0; e < 6; e++) begin
      for (int j = 0; j < N; j++) begin
        int a;
        a = (e == 3 || e == 4) ? (N - 1 - j) : j;
        if (e > 0) begin
          o.rw = 1'b0; o.addr = a; o.data = bg(e - 1);
          ref_q.push_back(o);
          seen = bg(e - 1);
          if (f_on && a == fa) seen[fb] = sv;
          if (kfail < 0 && seen != bg(e - 1)) begin
            kfail = ref_q.size() - 1;
            exp_fail = 1; exp_faddr = a; exp_felem = e;
          end
        end
        if (e < 5) begin
          o.rw = 1'b1; o.addr = a; o.data = bg(e);
          ref_q.push_back(o);
        end
      end
    end
    exp_ops = ref_q.size();
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    if (kfail >= 0 && kfail + 2 < exp_ops) exp_ops = kfail + 2;
    while (ref_q.size() > exp_ops) void'(ref_q.pop_back());
`endif
  endtask

  function automatic int ops_diff();
    int n;
    n = (obs_q.size() < ref_q.size()) ? obs_q.size() : ref_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i].rw !== ref_q[i].rw || obs_q[i].addr != ref_q[i].addr ||
          (ref_q[i].rw && obs_q[i].data !== ref_q[i].data))
        return i;
    end
    if (obs_q.size() != ref_q.size()) return n;
    return -1;
  endfunction

  // Pulse (or hold) start and record the bus until done, bounded
  task automatic do_run(input bit hold);
    int cyc;
    op_t o;
    obs_q.delete();
    busy_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) if (!hold) start = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (busy) busy_cnt++;
      if (mem_en) begin
        o.rw = mem_rw; o.addr = int'(mem_addr); o.data = mem_in;
        obs_q.push_back(o);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, fail, mem_en, mem_rw, mem_addr, mem_in, fail_addr, fail_element} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got busy=%b done=%b fail=%b en=%b rw=%b addr=%0d in=%h fa=%0d fe=%0d, want all 0",
               busy, done, fail, mem_en, mem_rw, mem_addr, mem_in, fail_addr, fail_element);
    end
    start = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, mem_en} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b en=%b, want 000", busy, done, mem_en);
    end
  endtask

  task automatic test_clean_run;
    int d;
    flt_on = 1'b0;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    build_ref(1'b0, 0, 0, 1'b0);
    do_run(1'b0);
    d = ops_diff();
    n_cmp++;
    if (timed_out) begin n_bad++; $display("FAIL clean_done: done=%b, want 1 within bound", done); end
    n_cmp++;
    if (d !== -1) begin n_bad++; $display("FAIL clean_ops: first divergence at op %0d (got %0d ops, want %0d)", d, obs_q.size(), ref_q.size()); end
    n_cmp++;
    if (busy_cnt !== exp_ops + LAT) begin n_bad++; $display("FAIL clean_busy: got %0d cycles, want %0d", busy_cnt, exp_ops + LAT); end
    n_cmp++;
    if (fail !== 1'b0) begin n_bad++; $display("FAIL clean_fail: got %b, want 0", fail); end
  endtask

  task automatic test_stuck_fault;
    int d;
    for (int t = 0; t < 5; t++) begin
      if (t == 0) begin
        flt_addr = 5; flt_bit = 0; flt_val = 1'b1;
      end else begin
        flt_addr = $urandom_range(0, N - 1);
        flt_bit  = $urandom_range(0, DW - 1);
        flt_val  = 1'($urandom_range(0, 1));
      end
      flt_on = 1'b1;
      build_ref(1'b1, flt_addr, flt_bit, flt_val);
      do_run(1'b0);
      d = ops_diff();
      n_cmp++;
      if (timed_out) begin n_bad++; $display("FAIL fault%0d_done: done=%b, want 1 within bound", t, done); end
      n_cmp++;
      if (d !== -1) begin n_bad++; $display("FAIL fault%0d_ops: first divergence at op %0d (got %0d ops, want %0d)", t, d, obs_q.size(), ref_q.size()); end
      n_cmp++;
      if (busy_cnt !== exp_ops + LAT) begin n_bad++; $display("FAIL fault%0d_busy: got %0d cycles, want %0d", t, busy_cnt, exp_ops + LAT); end
      n_cmp++;
      if ({fail, fail_addr, fail_element} !== {1'(exp_fail), 4'(exp_faddr), 3'(exp_felem)}) begin
        n_bad++;
        $display("FAIL fault%0d_capture: got fail=%b addr=%0d elem=%0d, want fail=%0d addr=%0d elem=%0d",
                 t, fail, fail_addr, fail_element, exp_fail, exp_faddr, exp_felem);
      end
    end
    flt_on = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int rc, d;
    flt_on = 1'b1; flt_addr = 5; flt_bit = 0; flt_val = 1'b1;
    rc = $urandom_range(35, 150);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (rc) @(negedge clk);
    n_cmp++;
    if (fail !== 1'b1) begin n_bad++; $display("FAIL midrst_prefail: got %b, want 1", fail); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, mem_en, fail} !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst_outs: got busy=%b done=%b en=%b fail=%b, want 0000", busy, done, mem_en, fail);
    end
    rst_n = 1'b1; flt_on = 1'b0;
    @(negedge clk);
    build_ref(1'b0, 0, 0, 1'b0);
    do_run(1'b0);
    d = ops_diff();
    n_cmp++;
    if (timed_out || d !== -1 || fail !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_rerun: got timeout=%b divergence=%0d fail=%b, want 0/-1/0", timed_out, d, fail);
    end
  endtask

  task automatic test_start_handling;
    int d;
    flt_on = 1'b1; flt_addr = 5; flt_bit = 0; flt_val = 1'b1;
    build_ref(1'b1, 5, 0, 1'b1);
    do_run(1'b1);
    d = ops_diff();
    n_cmp++;
    if (timed_out || d !== -1) begin
      n_bad++;
      $display("FAIL hold_ops: got timeout=%b divergence=%0d (ops %0d), want 0/-1 (ops %0d)", timed_out, d, obs_q.size(), ref_q.size());
    end
    n_cmp++;
    if ({done, fail} !== 2'b11) begin n_bad++; $display("FAIL hold_status: got done=%b fail=%b, want 11", done, fail); end
    flt_on = 1'b0;
    build_ref(1'b0, 0, 0, 1'b0);
    do_run(1'b0);
    d = ops_diff();
    n_cmp++;
    if (timed_out || d !== -1 || busy_cnt !== exp_ops + LAT) begin
      n_bad++;
      $display("FAIL restart_run: got timeout=%b divergence=%0d busy=%0d, want 0/-1/%0d", timed_out, d, busy_cnt, exp_ops + LAT);
    end
    n_cmp++;
    if ({done, fail} !== 2'b10) begin n_bad++; $display("FAIL restart_status: got done=%b fail=%b, want 10", done, fail); end
  endtask

  task automatic test_back_to_back;
    int d;
    for (int t = 0; t < 3; t++) begin
      flt_on   = 1'($urandom_range(0, 1));
      flt_addr = $urandom_range(0, N - 1);
      flt_bit  = $urandom_range(0, DW - 1);
      flt_val  = 1'($urandom_range(0, 1));
      build_ref(flt_on, flt_addr, flt_bit, flt_val);
      do_run(1'b0);
      d = ops_diff();
      n_cmp++;
      if (timed_out || d !== -1 || busy_cnt !== exp_ops + LAT) begin
        n_bad++;
        $display("FAIL b2b%0d_run: got timeout=%b divergence=%0d busy=%0d, want 0/-1/%0d", t, timed_out, d, busy_cnt, exp_ops + LAT);
      end
      n_cmp++;
      if ({fail, fail_addr, fail_element} !== {1'(exp_fail), 4'(exp_fail ? exp_faddr : 0), 3'(exp_fail ? exp_felem : 0)}) begin
        n_bad++;
        $display("FAIL b2b%0d_capture: got fail=%b addr=%0d elem=%0d, want fail=%0d addr=%0d elem=%0d",
                 t, fail, fail_addr, fail_element, exp_fail, exp_faddr, exp_felem);
      end
    end
    flt_on = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_clean_run();
    test_stuck_fault();
    test_reset_mid_run();
    test_start_handling();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_bist.md
Name: sram_bist

Overview:
- March C- built-in self-test controller for the generic synchronous `sram` block.
- Sits directly upstream of the `sram`: it drives `en`/`rw`/`addr`/`in` and consumes `out`.
- Muxed in front of the memory during test mode; reports pass/fail and the first failing location to the test/system controller.

Parameters:
- SIZE, 16, number of SRAM words; must match the attached `sram`; ≥2.
- DATA_WIDTH, 4, SRAM word width.
- READ_LATENCY, 1, clock edges from read issue (en=1, rw=0) to valid `out`; 1..4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset.
- start  in  1  begin test; sampled only in IDLE and DONE.
- busy  out  1  high while test in progress.
- done  out  1  high in DONE until next start or reset.
- fail  out  1  sticky; any mismatch since last start.
- fail_addr  out  $clog2(SIZE)  address of first mismatch.
- fail_element  out  3  March element (0..5) of first mismatch.
- mem_en  out  1  to sram en.
- mem_rw  out  1  to sram rw (1=write, 0=read).
- mem_addr  out  $clog2(SIZE)  to sram addr.
- mem_in  out  DATA_WIDTH  to sram in.
- mem_out  in  DATA_WIDTH  from sram out.

Interface note: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; all outputs 0; read-tracking pipeline cleared. Reset mid-test aborts immediately; the next edge with rst_n=1 is IDLE.
- Outputs: all mem_* and status outputs are registered.
- Data background: "0" = all-zeros word; "1" = all-ones word.
- March sequence, N=SIZE:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 up(r0)
  - up = addr 0..N-1; down = N-1..0.
- Issue rate: one op per cycle, mem_en=1 every RUN cycle, no bubbles. Total issue cycles = 10N (160 for N=16).
- Within an element, the read and write of the same address are in consecutive cycles, read first.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 → RUN. Clear fail/fail_addr/fail_element. busy=1 from the next cycle.
  - RUN: sequence element/address/op counters. After the last M5 read is issued → DRAIN, with mem_en=0.
  - DRAIN: hold for READ_LATENCY cycles so outstanding reads compare → DONE.
  - DONE: busy=0, done=1. start=1 → RUN, same as from IDLE (done drops).
- start during RUN/DRAIN is ignored.
- Read checking:
  - Each read issue pushes {valid, expected word, addr, element} into a READ_LATENCY-deep shift pipeline.
  - At pipeline output, valid && mem_out != expected → mismatch.
  - First mismatch sets fail=1 and captures fail_addr/fail_element.
  - Later mismatches leave the captured values unchanged.
- Idle outputs: mem_en=0, mem_rw=0; mem_addr and mem_in hold their last values.
- Counter widths: address counter $clog2(SIZE) bits. Down-count wraps to stop at 0, never underflows into the next element.

Optional Feature:
- Macro: SRAM_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch aborts issue. The next cycle enters DRAIN with mem_en=0, then DONE with fail=1. Remaining March ops are not issued.
- Undefined: the test always runs all 10N ops; fail is sticky with first-failure capture only.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with start=1 → busy=0, done=0, fail=0, mem_en=0, mem_addr=0; stays IDLE until rst_n=1.
2. Clean run (SIZE=16, DW=4, LAT=1, real `sram`): start pulse → busy high exactly 160+1 cycles, then done=1, fail=0.
   - mem_addr during M3 is 15..0 descending.
   - mem_in alternates 4'hF/4'h0 across M1/M2.
3. Stuck-at-1 fault: bench forces mem_out[0]=1 whenever the read addr is 5 → fail=1, fail_addr=5, fail_element=1; done after 161 cycles (macro undefined).
4. SRAM_BIST_STOP_ON_FAIL_EN defined, same fault → done asserts 1+READ_LATENCY+1 cycles after the M1 read of addr 5 issues; fewer than 30 mem_en cycles total.
5. Reset mid-run: rst_n=0 at cycle 50 → next edge busy=0, mem_en=0, fail=0. Restart start → clean completion with fail=0.
6. Start handling: start held high through RUN → no restart. Start in DONE after a failing run with the fault removed → fail clears, run passes, done=1.
